ram_port_arbiter: RTL

- Shares the single port of the 128x32 parameter RAM between N requesters: RX packet writer (req 0), TX reply reader (req 1), AES key/data fetch (req 2).
- Takes the place of direct RAM wiring from the RX decoder.
- Each requester uses a req/ack handshake. The arbiter registers the winning request, drives the RAM for one access, waits out the read latency and returns read data with a one-cycle ack.

---
 rtl/ram_port_arbiter_pkg.sv | 25 ++
 rtl/ram_port_arbiter_if.sv | 36 +++
 rtl/ram_port_arbiter_rr_select.sv | 42 ++++
 rtl/ram_port_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the parameter-RAM port arbiter.
// Pure declarations: no timing, no flow control.
package ram_arb_pkg;

  localparam int ARB_ADDR_W = 7;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } arb_state_t;

  // Width of an index into n items, never less than one bit.
  function automatic int arb_clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 16; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side bundle of the parameter-RAM arbiter.
// master = requesters plus RAM model; slave = the arbiter itself.
interface ram_port_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) ();

  localparam int GW = arb_clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        we;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       rdata;
  logic [GW-1:0]           grant_id;
  logic                    busy;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       ram_wdata;
  logic                    ram_we;
  logic [DATA_W-1:0]       ram_rdata;

  modport master (
    output req, we, addr, wdata, ram_rdata,
    input  ack, rdata, grant_id, busy, ram_addr, ram_wdata, ram_we
  );

  modport slave (
    input  req, we, addr, wdata, ram_rdata,
    output ack, rdata, grant_id, busy, ram_addr, ram_wdata, ram_we
  );

endinterface

// File: rtl/ram_port_arbiter_rr_select.sv
// Combinational winner pick: round-robin after last_grant, or lowest index with ARB_FIXED_PRIO_EN.
// Zero latency; win_vld low when nothing requests.
module rr_select
  import ram_arb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int GW    = arb_clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last_grant,
  output logic [GW-1:0]    win_id,
  output logic             win_vld
);

  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_id  = GW'(i);
        win_vld = 1'b1;
      end
    end
`else
    // Wrapped group first, then the group above last_grant overrides it.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i] && (GW'(i) <= last_grant)) begin
        win_id  = GW'(i);
        win_vld = 1'b1;
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i] && (GW'(i) > last_grant)) begin
        win_id  = GW'(i);
        win_vld = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter for N req/ack requesters; ARB_FIXED_PRIO_EN selects fixed priority over round-robin.
// Latency req->ack: write 2, read 2+RD_LAT cycles; losers hold req and wait, nothing is dropped.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  ram_port_arbiter_if.slave  bus
);

  localparam int GW = arb_clog2(N_REQ);
  localparam int CW = (RD_LAT > 1) ? arb_clog2(RD_LAT) : 1;

  arb_state_t        state_q, state_nxt;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_nxt;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_nxt;
  logic              ram_we_q, ram_we_nxt;
  logic              we_q, we_nxt;
  logic [CW-1:0]     wait_q, wait_nxt;
  logic [DATA_W-1:0] rdata_q, rdata_nxt;
  logic [N_REQ-1:0]  ack_q, ack_nxt;
  logic [GW-1:0]     grant_q, grant_nxt;
  logic [GW-1:0]     last_q, last_nxt;
  logic              busy_q, busy_nxt;
  logic [GW-1:0]     win_id;
  logic              win_vld;

  rr_select #(.N_REQ(N_REQ), .GW(GW)) u_sel (
    .req        (bus.req),
    .last_grant (last_q),
    .win_id     (win_id),
    .win_vld    (win_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      we_q        <= 1'b0;
      wait_q      <= '0;
      rdata_q     <= '0;
      ack_q       <= '0;
      grant_q     <= '0;
      last_q      <= GW'(N_REQ - 1);
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      ram_addr_q  <= ram_addr_nxt;
      ram_wdata_q <= ram_wdata_nxt;
      ram_we_q    <= ram_we_nxt;
      we_q        <= we_nxt;
      wait_q      <= wait_nxt;
      rdata_q     <= rdata_nxt;
      ack_q       <= ack_nxt;
      grant_q     <= grant_nxt;
      last_q      <= last_nxt;
      busy_q      <= busy_nxt;
    end
  end

  // Every output is a register, so each *_nxt describes the value for the next state.
  always_comb begin
    state_nxt     = state_q;
    ram_addr_nxt  = ram_addr_q;
    ram_wdata_nxt = ram_wdata_q;
    ram_we_nxt    = 1'b0;
    we_nxt        = we_q;
    wait_nxt      = wait_q;
    rdata_nxt     = rdata_q;
    ack_nxt       = '0;
    grant_nxt     = grant_q;
    last_nxt      = last_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          ram_addr_nxt  = bus.addr[int'(win_id)*ADDR_W +: ADDR_W];
          ram_wdata_nxt = bus.wdata[int'(win_id)*DATA_W +: DATA_W];
          we_nxt        = bus.we[win_id];
          ram_we_nxt    = bus.we[win_id];
          grant_nxt     = win_id;
          state_nxt     = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          ack_nxt[grant_q] = 1'b1;
          state_nxt        = DONE;
        end else begin
          wait_nxt  = CW'(RD_LAT - 1);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (wait_q == '0) begin
          rdata_nxt        = bus.ram_rdata;
          ack_nxt[grant_q] = 1'b1;
          state_nxt        = DONE;
        end else begin
          wait_nxt = wait_q - CW'(1);
        end
      end
      DONE: begin
        last_nxt  = grant_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.rdata     = rdata_q;
  assign bus.ack       = ack_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = busy_q;

endmodule
